// File: rtl/ram_dp_scan.sv
// ram_dp_scan
//   Simple-dual-port RAM (2^ADDR_W x DATA_W) whose read address is produced
//   by a built-in sequencer. The sequencer can hold, auto-scan up or down on
//   a divided tick, or single-step on a rising edge of a button level.
//
// Parameters
//   DATA_W  word width in bits (1..32)
//   ADDR_W  address width, depth = 2^ADDR_W (1..10)
//   TICK_M  prescaler modulus in clk cycles per scan tick (>= 2)
//
// Ports
//   clk      rising-edge clock
//   aclr     asynchronous active-high reset (memory contents are kept)
//   we       write enable
//   wr_addr  write address
//   wr_data  write data
//   mode     00 hold, 01 scan up, 10 scan down, 11 step
//   step     step request level, synchronous to clk
//   rd_addr  current read address (registered)
//   rd_data  registered read data, write-through on address match
//   adv      one-cycle pulse: rd_addr changed on this edge
//   wrap     one-cycle pulse: rd_addr wrapped on this edge
module ram_dp_scan #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 5,
  parameter int TICK_M = 50000000
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              adv,
  output logic              wrap
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (TICK_M > 1) ? $clog2(TICK_M) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_M - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_MIN = '0;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_STEP = 2'b11;

  // ---------------------------------------------------------------------
  // Storage. No reset on the array so it maps onto block RAM and survives
  // aclr.
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // ---------------------------------------------------------------------
  // Prescaler: free-running in every mode so switching modes never shifts
  // the scan phase.
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)      cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Step edge detect. step_d resets high so a button already held while
  // aclr releases does not count as a press. step_d tracks step in every
  // mode, so a rise seen outside step mode is simply dropped.
  // ---------------------------------------------------------------------
  logic step_d;
  logic rise;

  assign rise = step & ~step_d;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) step_d <= 1'b1;
    else      step_d <= step;
  end

  // ---------------------------------------------------------------------
  // Advance decision.
  // ---------------------------------------------------------------------
  logic              inc;
  logic              dec;
  logic [ADDR_W-1:0] addr_nxt;
  logic              wrap_nxt;

  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    case (mode)
      MODE_HOLD: ;
      MODE_UP:   inc = tick;
      MODE_DN:   dec = tick;
      MODE_STEP: inc = rise;
      default:   ;
    endcase
  end

  always_comb begin
    addr_nxt = rd_addr;
    wrap_nxt = 1'b0;
    if (inc) begin
      addr_nxt = rd_addr + 1'b1;
      wrap_nxt = (rd_addr == ADDR_MAX);
    end else if (dec) begin
      addr_nxt = rd_addr - 1'b1;
      wrap_nxt = (rd_addr == ADDR_MIN);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rd_addr <= '0;
      adv     <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      rd_addr <= addr_nxt;
      adv     <= inc | dec;
      wrap    <= wrap_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Read port. Uses the pre-edge rd_addr; a same-edge write to that address
  // is forwarded so the display never shows a stale word.
  // ---------------------------------------------------------------------
  logic byp;

  assign byp = we && (wr_addr == rd_addr);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)     rd_data <= '0;
    else if (byp) rd_data <= wr_data;
    else          rd_data <= mem[rd_addr];
  end

endmodule
